// File: rtl/mcpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl_pkg
// Shared definitions for the multicycle CPU controller:
//   - state_e     : FSM state encodings (also shown on the debug 'state' port)
//   - OP_*        : instruction opcode field values (instruction[31:26])
//   - FUN_*       : R-type funct field values (instruction[5:0])
//   - ALU_*       : ALU_Control codes driven to the datapath ALU
//   - alu_op_e    : coarse ALU request from the FSM to mcpu_alu_dec
// ---------------------------------------------------------------------------
package mcpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_MA   = 5'd2,
    S_MRD  = 5'd3,
    S_WLW  = 5'd4,
    S_MWR  = 5'd5,
    S_EX_R = 5'd6,
    S_WR   = 5'd7,
    S_BEQ  = 5'd8,
    S_JMP  = 5'd9,
    S_AEX  = 5'd10,
    S_AWB  = 5'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUN_ADD = 6'b100000;
  localparam logic [5:0] FUN_SUB = 6'b100010;
  localparam logic [5:0] FUN_AND = 6'b100100;
  localparam logic [5:0] FUN_OR  = 6'b100101;
  localparam logic [5:0] FUN_SLT = 6'b101010;
  localparam logic [5:0] FUN_NOR = 6'b100111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  // What the FSM wants from the ALU; FUNCT defers to the instruction's funct field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

endpackage

// File: rtl/mcpu_alu_dec.sv
// ---------------------------------------------------------------------------
// mcpu_alu_dec
// Translates the FSM's coarse ALU request into the 3-bit ALU_Control code.
// Ports:
//   alu_op   in  alu_op_e  add / sub / decode-from-funct request
//   fun      in  6         instruction[5:0] (funct field)
//   alu_ctrl out 3         ALU_Control code
// Unknown funct values fall back to add so an odd R-type behaves predictably.
// ---------------------------------------------------------------------------
module mcpu_alu_dec
  import mcpu_ctrl_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [5:0]  fun,
  output logic [2:0]  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (fun)
          FUN_ADD: alu_ctrl = ALU_ADD;
          FUN_SUB: alu_ctrl = ALU_SUB;
          FUN_AND: alu_ctrl = ALU_AND;
          FUN_OR:  alu_ctrl = ALU_OR;
          FUN_SLT: alu_ctrl = ALU_SLT;
          FUN_NOR: alu_ctrl = ALU_NOR;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl
// Moore-style control FSM for a MIPS-like multicycle datapath. Outputs decode
// combinationally from the registered state (plus MIO_ready in IF, Fun in
// EX_R/WR), so a reset drops any memory strobe in the same cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   OPcode[5:0], Fun[5:0]    instruction fields from the IR
//   zero                     ALU zero flag (the datapath gates PCWriteCond with it)
//   MIO_ready                memory access completes this cycle
//   PCWrite .. CPU_MIO       1-bit datapath strobes / selects
//   ALUSrc_B[1:0]            00 B, 01 const 4, 10 imm, 11 imm<<2
//   PCSource[1:0]            00 ALU, 01 ALUOut, 10 jump target
//   ALU_Control[2:0]         ALU operation code
//   state[4:0]               current FSM state (debug)
// Configuration macro:
//   MCPU_ADDI_EN  when defined, addi (001000) runs ID -> AEX -> AWB -> IF;
//                 otherwise addi is a nop and states 10/11 are unused.
// ---------------------------------------------------------------------------
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       mem_w,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       CPU_MIO,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic [4:0] state
);

  state_e  state_q, state_d;
  alu_op_e alu_op;

  // The branch decision is made in the datapath (PCWriteCond & zero), so the
  // controller only carries the flag through its interface.
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state logic. Wait states (IF, MRD, MWR) hold until memory is ready;
  // unrecognised opcodes and unused state codes fall back to IF.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (MIO_ready) state_d = S_ID;
      S_ID: begin
        case (OPcode)
          OP_LW, OP_SW: state_d = S_MA;
          OP_RTYPE:     state_d = S_EX_R;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
`ifdef MCPU_ADDI_EN
          OP_ADDI:      state_d = S_AEX;
`endif
          default:      state_d = S_IF;
        endcase
      end
      S_MA: begin
        if (OPcode == OP_LW)      state_d = S_MRD;
        else if (OPcode == OP_SW) state_d = S_MWR;
        else                      state_d = S_IF;
      end
      S_MRD:  if (MIO_ready) state_d = S_WLW;
      S_WLW:  state_d = S_IF;
      S_MWR:  if (MIO_ready) state_d = S_IF;
      S_EX_R: state_d = S_WR;
      S_WR:   state_d = S_IF;
      S_BEQ:  state_d = S_IF;
      S_JMP:  state_d = S_IF;
`ifdef MCPU_ADDI_EN
      S_AEX:  state_d = S_AWB;
      S_AWB:  state_d = S_IF;
`endif
      default: state_d = S_IF;
    endcase
  end

  // State register; reset forces IF immediately, aborting any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Output decode. Everything defaults low with an add request; each state
  // raises only what it needs. IF gates its write strobes with MIO_ready so
  // the PC and IR only capture a completed fetch.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    mem_w       = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    Branch      = 1'b0;
    CPU_MIO     = 1'b0;
    ALUSrc_B    = 2'b00;
    PCSource    = 2'b00;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_IF: begin
        MemRead  = 1'b1;
        CPU_MIO  = 1'b1;
        ALUSrc_B = 2'b01;
        IRWrite  = MIO_ready;
        PCWrite  = MIO_ready;
      end
      S_ID: begin
        ALUSrc_B = 2'b11;
      end
      S_MA: begin
        ALUSrcA  = 1'b1;
        ALUSrc_B = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
      end
      S_WLW: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MWR: begin
        mem_w   = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
      end
      S_EX_R: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      // The IR is unchanged in WR, so re-decoding Fun keeps the EX_R ALU code.
      S_WR: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        alu_op   = ALUOP_FUNCT;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        alu_op      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        Branch      = 1'b1;
        PCSource    = 2'b01;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MCPU_ADDI_EN
      S_AEX: begin
        ALUSrcA  = 1'b1;
        ALUSrc_B = 2'b10;
      end
      S_AWB: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  mcpu_alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .fun      (Fun),
    .alu_ctrl (ALU_Control)
  );

  assign state = state_q;

endmodule
